// File: rtl/instr_fetcher.sv
// Front-end fetch stage: fetches one word at pc, holds it for the decoder.
// Optional direct-mapped icache when ICACHE_EN is defined.
module instr_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT_MEM,
    S_HOLD,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic        hold_valid_q, hold_valid_d;

  logic        hit;
  logic [31:0] hit_data;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  logic [LINES-1:0]        cache_valid_q;
  logic [TAG_W-1:0]        cache_tag_q  [LINES];
  logic [31:0]             cache_data_q [LINES];
  logic [ICACHE_IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic                    fill_en;

  assign pc_idx   = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag   = pc_q[31:ICACHE_IDX_W+2];
  assign hit      = cache_valid_q[pc_idx] &&
                    (cache_tag_q[pc_idx] == pc_tag);
  assign hit_data = cache_data_q[pc_idx];
  // only data accepted into HOLD is cached; flushed responses are not
  assign fill_en  = rdy && !rob_clear && mem_ready &&
                    (state_q == S_WAIT_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= '0;
    end else if (fill_en) begin
      cache_valid_q[pc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      cache_tag_q[pc_idx]  <= pc_tag;
      cache_data_q[pc_idx] <= mem_data;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    hold_valid_d = hold_valid_q;
    if (rob_clear) begin
      pc_d         = {rob_new_pc[31:2], 2'b00};
      hold_valid_d = 1'b0;
      unique case (state_q)
        S_WAIT_MEM, S_DISCARD: begin
          if (mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            state_d   = S_DISCARD;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = S_FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (hit) begin
            instr_d      = hit_data;
            instr_addr_d = pc_q;
            hold_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            mem_req_d    = 1'b1;
            mem_addr_d   = pc_q;
            state_d      = S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (mem_ready) begin
            instr_d      = mem_data;
            instr_addr_d = pc_q;
            hold_valid_d = 1'b1;
            mem_req_d    = 1'b0;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_issued) begin
            hold_valid_d = 1'b0;
            pc_d         = {predict_pc[31:2], 2'b00};
            state_d      = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      instr_q      <= 32'h0;
      instr_addr_q <= 32'h0;
      hold_valid_q <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign instr_out      = instr_q;
  assign instr_addr_out = instr_addr_q;
  // decoder's issue flag is registered: mask it so nothing issues twice
  assign instr_ready    = hold_valid_q && !instr_issued;

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher with a latency-programmable memory.
// Define ICACHE_EN to also exercise the icache hit path.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear;
  logic [31:0] rob_new_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        instr_ready;
  logic [31:0] instr_out, instr_addr_out;
  logic        instr_issued;
  logic [31:0] predict_pc;

  always #5 clk = ~clk;

  instr_fetcher dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rob_clear      (rob_clear),
    .rob_new_pc     (rob_new_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_addr_out (instr_addr_out),
    .instr_issued   (instr_issued),
    .predict_pc     (predict_pc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 2;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] raddr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h8:   return 32'hDEAD_BEEF;
      default: return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  initial begin
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_data  = mem_word(raddr);
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mem_req) begin
        pend  = 1'b1;
        raddr = mem_addr;
        cnt   = lat;
        req_q.push_back(mem_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.data = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic wait_instr(input string tag);
    int   i;
    logic bad;
    exp_t e;
    i   = 0;
    bad = 1'b0;
    while (!instr_ready && i < 60) begin
      step();
      if (instr_out === 32'hDEAD_BEEF) bad = 1'b1;
      i++;
    end
    chk({tag, "_ready"}, {31'h0, instr_ready}, 32'h1);
    chk({tag, "_no_stale"}, {31'h0, bad}, 32'h0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, instr_addr_out, e.addr);
      chk({tag, "_data"}, instr_out, e.data);
    end
  endtask

  task automatic expect_req(input string tag, input logic [31:0] a);
    if (req_q.size() == 0) chk({tag, "_missing"}, 32'h0, 32'h1);
    else chk(tag, req_q.pop_front(), a);
  endtask

  task automatic issue(input logic [31:0] p);
    instr_issued = 1'b1;
    predict_pc   = p;
    #1;
    chk("ready_masked", {31'h0, instr_ready}, 32'h0);
    step();
    instr_issued = 1'b0;
    chk("ready_after_issue", {31'h0, instr_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    rdy          = 1'b1;
    rob_clear    = 1'b0;
    rob_new_pc   = 32'h0;
    instr_issued = 1'b0;
    predict_pc   = 32'h0;
    repeat (3) step();
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ready", {31'h0, instr_ready}, 32'h0);
    chk("rst_iout", instr_out, 32'h0);
    chk("rst_iaddr", instr_addr_out, 32'h0);
    rst = 1'b0;
    step();
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", mem_addr, 32'h0);
    push_exp(32'h0);
    wait_instr("i0");
    expect_req("req0", 32'h0);

    issue(32'h4);
    push_exp(32'h4);
    wait_instr("i4");
    expect_req("req4", 32'h4);

    repeat (10) begin
      step();
      chk("stall_ready", {31'h0, instr_ready}, 32'h1);
      chk("stall_addr", instr_addr_out, 32'h4);
      chk("stall_data", instr_out, mem_word(32'h4));
      chk("stall_req", {31'h0, mem_req}, 32'h0);
    end

    rdy          = 1'b0;
    instr_issued = 1'b1;
    predict_pc   = 32'h80;
    step();
    step();
    instr_issued = 1'b0;
    rdy          = 1'b1;
    #1;
    chk("freeze_ready", {31'h0, instr_ready}, 32'h1);
    chk("freeze_addr", instr_addr_out, 32'h4);

    lat = 4;
    issue(32'h0000_000B);
    step();
    chk("fl_req", {31'h0, mem_req}, 32'h1);
    chk("fl_addr", mem_addr, 32'h8);
    rob_clear  = 1'b1;
    rob_new_pc = 32'h100;
    step();
    rob_clear  = 1'b0;
    push_exp(32'h100);
    wait_instr("flush");
    expect_req("req8", 32'h8);
    expect_req("req100", 32'h100);
    lat = 2;

    instr_issued = 1'b1;
    predict_pc   = 32'h20;
    rob_clear    = 1'b1;
    rob_new_pc   = 32'h43;
    step();
    instr_issued = 1'b0;
    rob_clear    = 1'b0;
    push_exp(32'h40);
    wait_instr("coinc");
    expect_req("req40", 32'h40);

    issue(32'hFFFF_FFFF);
    push_exp(32'hFFFF_FFFC);
    wait_instr("wrap");
    expect_req("reqwrap", 32'hFFFF_FFFC);

    issue(32'h0);
    push_exp(32'h0);
    wait_instr("loop0");
    expect_req("reqloop0", 32'h0);

    issue(32'h0);
    push_exp(32'h0);
`ifdef ICACHE_EN
    step();
    chk("hit_ready", {31'h0, instr_ready}, 32'h1);
    chk("hit_req", {31'h0, mem_req}, 32'h0);
    wait_instr("hit");
`else
    wait_instr("loop1");
    expect_req("reqloop1", 32'h0);
`endif

    chk("sb_empty", sb.size(), 32'h0);
    chk("req_left", req_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Front-end stage that fetches 32-bit instructions from the memory controller at the current PC.
- Holds one fetched instruction and presents it to the decoder.
- After the decoder issues it, the block takes the decoder's predicted next PC.
- On a RoB flush it redirects to the corrected PC and discards any in-flight fetch.

Parameters:
RESET_PC, 32'h0, PC loaded on reset.
ICACHE_IDX_W, 4, index width of optional direct-mapped icache (2^ICACHE_IDX_W lines of one word each).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; when low, all state frozen
rob_clear  in  1  flush pulse from RoB
rob_new_pc  in  32  redirect target, valid with rob_clear
mem_req  out  1  fetch request to memory controller
mem_addr  out  32  fetch address (word aligned)
mem_ready  in  1  one-cycle pulse: mem_data valid
mem_data  in  32  fetched instruction word
instr_ready  out  1  instruction valid to decoder
instr_out  out  32  instruction word
instr_addr_out  out  32  PC of instr_out
instr_issued  in  1  decoder issued the held instruction (registered in decoder)
predict_pc  in  32  decoder's next-PC, valid in the same cycle as instr_issued

Behaviour:
- Reset values:
  - state=FETCH, pc=RESET_PC, mem_req=0, mem_addr=0, instr_out=0, instr_addr_out=0, hold_valid=0.
  - With ICACHE_EN, all icache valid bits=0.
- rdy=0: no register changes; outputs hold.
- instr_ready = hold_valid && !instr_issued (combinational).
  - Masks the cycle in which the decoder's registered issue flag is high, so the held instruction is never issued twice.
- States:
  - FETCH:
    - Drive mem_req=1, mem_addr=pc.
    - Registered; mem_req is high from the cycle after entry.
    - Next state WAIT_MEM.
  - WAIT_MEM:
    - Hold mem_req=1 and mem_addr.
    - On mem_ready: instr_out<=mem_data, instr_addr_out<=pc, hold_valid<=1, mem_req<=0, next HOLD.
  - HOLD:
    - On instr_issued: hold_valid<=0, pc<=predict_pc, next FETCH.
    - Otherwise stay in HOLD with outputs stable.
  - DISCARD:
    - mem_req stays 1 until mem_ready.
    - On mem_ready: drop mem_data, mem_req<=0, next FETCH using the redirected pc.
- Flush (rob_clear=1 while rdy=1) has priority over every other event in the same cycle:
  - pc<=rob_new_pc, hold_valid<=0.
  - In WAIT_MEM with mem_ready=0: next DISCARD.
  - In WAIT_MEM with mem_ready=1 in the same cycle: data dropped, next FETCH.
  - In DISCARD: stay in DISCARD, pc updated.
  - Otherwise: next FETCH.
  - An instr_issued seen in the same cycle is ignored.
- mem_addr[1:0] is always 0. Low bits of predict_pc and rob_new_pc are forced to 0.
- PC arithmetic is 32-bit wrap-around; no fault on 0xFFFFFFFC.
- Latency without cache: issue seen to next instr_ready high = 2 cycles + memory latency.
- A mem_ready pulse arriving in FETCH or HOLD is ignored; the memory controller never produces one.

Optional Feature:
- Macro: ICACHE_EN.
- Defined:
  - Direct-mapped icache, index = pc[ICACHE_IDX_W+1:2], tag = pc[31:ICACHE_IDX_W+2].
  - In FETCH, on a hit: instr_out/instr_addr_out load next edge, hold_valid<=1, next HOLD, mem_req stays 0.
  - On a miss: normal path. Every accepted mem_ready in WAIT_MEM fills the line.
  - Data dropped in DISCARD or in the flush cycle is not written to the cache.
  - rst clears all valid bits; rob_clear does not.
- Not defined: no cache storage; every fetch goes to memory.

Test Plan:
- Reset, RESET_PC=0:
  - First mem_req=1 with mem_addr=0 one cycle after rst drops.
  - mem_ready with mem_data=0x00500093 -> instr_ready=1, instr_out=0x00500093, instr_addr_out=0.
- Hold then issue, predict_pc=0x4:
  - instr_issued=1 -> instr_ready=0 that cycle.
  - Next fetch mem_addr=0x4; exactly one issue of instr_addr 0.
- Stall: instr_issued held low 10 cycles -> instr_ready, instr_out, instr_addr_out stable; mem_req=0 throughout.
- Flush mid-fetch:
  - rob_clear with rob_new_pc=0x100 during WAIT_MEM (addr 0x8).
  - Late mem_ready data 0xDEADBEEF never appears on instr_out.
  - Next mem_addr=0x100.
- Flush coincident with instr_issued and predict_pc=0x20, rob_new_pc=0x40 -> next fetch at 0x40.
- ICACHE_EN: fetch 0x0, issue with predict_pc=0x0 (loop) -> second fetch hits, mem_req stays 0, instr_ready high 2 cycles after issue.
